// File: rtl/adc_spi_master.sv
// adc_spi_master: one full-duplex SPI frame per accepted enable, MSB first.
// Optional SPI_LOOPBACK_EN adds a loopback input that samples mosi instead of miso.
module adc_spi_master #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4,
    parameter bit CPOL    = 1'b1,
    parameter bit CPHA    = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              soft_rst_n,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
`ifdef SPI_LOOPBACK_EN
    input  logic              loopback,
`endif
    input  logic              miso
);

    localparam int HW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        CS_GAP
    } state_t;

    state_t state, state_d;
    logic [HW-1:0] hcnt, hcnt_d, hnext;
    logic [BW-1:0] bcnt, bcnt_d;
    logic trail, trail_d;
    logic [DATA_W-1:0] tx_sh, tx_d;
    logic [DATA_W-1:0] rx_sh, rx_sh_d;
    logic [DATA_W-1:0] rx_data_d;
    logic sclk_d, cs_n_d, mosi_d, busy_d, rxv_d;
    logic lead, trl, hend, lbit, samp;

`ifdef SPI_LOOPBACK_EN
    assign samp = loopback ? mosi : miso;
`else
    assign samp = miso;
`endif

    assign hend  = (hcnt == H_LAST);
    assign lbit  = (bcnt == B_LAST);
    assign hnext = hend ? '0 : hcnt + 1'b1;

    always_comb begin
        state_d   = state;
        hcnt_d    = hcnt;
        bcnt_d    = bcnt;
        trail_d   = trail;
        tx_d      = tx_sh;
        rx_sh_d   = rx_sh;
        rx_data_d = rx_data;
        sclk_d    = sclk;
        cs_n_d    = cs_n;
        mosi_d    = mosi;
        busy_d    = busy;
        rxv_d     = 1'b0;
        lead      = 1'b0;
        trl       = 1'b0;
        if (!soft_rst_n) begin
            state_d = IDLE;
            hcnt_d  = '0;
            bcnt_d  = '0;
            trail_d = 1'b0;
            sclk_d  = CPOL;
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            busy_d  = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enable) begin
                        state_d = CS_SETUP;
                        hcnt_d  = '0;
                        busy_d  = 1'b1;
                        cs_n_d  = 1'b0;
                        tx_d    = tx_data;
                        // leading-edge samplers need the MSB on the pin before the first edge
                        if (!CPHA) begin
                            mosi_d = tx_data[DATA_W-1];
                            tx_d   = tx_data << 1;
                        end
                    end
                end
                CS_SETUP: begin
                    hcnt_d = hnext;
                    if (hend) begin
                        state_d = SHIFT;
                        bcnt_d  = '0;
                        trail_d = 1'b0;
                        sclk_d  = !CPOL;
                        lead    = 1'b1;
                    end
                end
                SHIFT: begin
                    hcnt_d = hnext;
                    if (hend) begin
                        if (!trail) begin
                            trail_d = 1'b1;
                            sclk_d  = CPOL;
                            trl     = 1'b1;
                        end else if (lbit) begin
                            state_d = CS_HOLD;
                            trail_d = 1'b0;
                        end else begin
                            trail_d = 1'b0;
                            bcnt_d  = bcnt + 1'b1;
                            sclk_d  = !CPOL;
                            lead    = 1'b1;
                        end
                    end
                end
                CS_HOLD: begin
                    hcnt_d = hnext;
                    if (hend) begin
                        state_d   = CS_GAP;
                        cs_n_d    = 1'b1;
                        rxv_d     = 1'b1;
                        rx_data_d = rx_sh;
                    end
                end
                CS_GAP: begin
                    hcnt_d = hnext;
                    if (hend) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
            if ((lead && !CPHA) || (trl && CPHA)) begin
                rx_sh_d = {rx_sh[DATA_W-2:0], samp};
            end
            if ((lead && CPHA) || (trl && !CPHA && !lbit)) begin
                mosi_d = tx_sh[DATA_W-1];
                tx_d   = tx_sh << 1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hcnt     <= '0;
            bcnt     <= '0;
            trail    <= 1'b0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_data  <= '0;
            sclk     <= CPOL;
            cs_n     <= 1'b1;
            mosi     <= 1'b0;
            busy     <= 1'b0;
            rx_valid <= 1'b0;
        end else begin
            state    <= state_d;
            hcnt     <= hcnt_d;
            bcnt     <= bcnt_d;
            trail    <= trail_d;
            tx_sh    <= tx_d;
            rx_sh    <= rx_sh_d;
            rx_data  <= rx_data_d;
            sclk     <= sclk_d;
            cs_n     <= cs_n_d;
            mosi     <= mosi_d;
            busy     <= busy_d;
            rx_valid <= rxv_d;
        end
    end

endmodule
